// File: rtl/axi_burst_rr_arbiter.sv
// Burst-granular round-robin arbiter: N_REQ valid/ready requesters share one
// downstream channel. A requester that is presented keeps the grant until its
// last beat is accepted, so the downstream beat stays stable under backpressure.
module axi_burst_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LOG_N_REQ  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        valid_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        last_o,
  input  logic                        ready_i,
  output logic [LOG_N_REQ-1:0]        grant_id_o,
  output logic                        locked_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state;
  logic [LOG_N_REQ-1:0]   rr_ptr;
  logic [LOG_N_REQ-1:0]   lock_id;
  logic [LOG_N_REQ-1:0]   arb_id;
  logic [LOG_N_REQ-1:0]   gnt_id;
  logic [LOG_N_REQ-1:0]   scan_id;
  logic                   any_req;
  logic                   active;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   hs;
  logic [DATA_WIDTH-1:0]  data_arr [N_REQ];
  int                     scan_k;

  // Index after id, wrapping at N_REQ-1 so non-power-of-2 counts work.
  function automatic logic [LOG_N_REQ-1:0] next_id(input logic [LOG_N_REQ-1:0] id);
    if (int'(id) == N_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // Unpack the flat payload bus into one word per requester.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin scan starting at rr_ptr; walking offsets downwards lets the
  // nearest valid requester overwrite any farther one.
  always_comb begin
    arb_id  = rr_ptr;
    any_req = 1'b0;
    scan_k  = 0;
    scan_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_k = int'(rr_ptr) + i;
      if (scan_k >= N_REQ) scan_k = scan_k - N_REQ;
      scan_id = LOG_N_REQ'(scan_k);
      if (req_valid_i[scan_id]) begin
        arb_id  = scan_id;
        any_req = 1'b1;
      end
    end
  end

  // Route the winner to the downstream port; ready_i only feeds back upstream,
  // never into valid_o. Everything is forced to zero while reset is held.
  always_comb begin
    gnt_id    = (state == LOCKED) ? lock_id : arb_id;
    active    = (state == LOCKED) || any_req;
    sel_valid = req_valid_i[gnt_id];
    sel_last  = req_last_i[gnt_id];
    hs        = sel_valid && ready_i;

    valid_o     = !rst_i && sel_valid;
    data_o      = (!rst_i && active) ? data_arr[gnt_id] : '0;
    last_o      = !rst_i && active && sel_last;
    grant_id_o  = rst_i ? '0 : gnt_id;
    req_ready_o = '0;
    if (!rst_i && active) req_ready_o[gnt_id] = ready_i;
  end

  // Burst lock FSM: hold the grant from the first presented beat until the
  // last beat handshakes, then advance the round-robin pointer past the winner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_id  <= '0;
      locked_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            if (hs && sel_last) begin
              rr_ptr <= next_id(gnt_id);
            end else begin
              state    <= LOCKED;
              lock_id  <= gnt_id;
              locked_o <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (hs && sel_last) begin
            state    <= IDLE;
            rr_ptr   <= next_id(lock_id);
            locked_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_rr_arbiter.sv
// Testbench for axi_burst_rr_arbiter: directed scenarios with fixed expected
// values plus a randomized run checked against a behavioural model.
module tb_axi_burst_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            valid;
  logic [DW-1:0]   data;
  logic            last;
  logic            ready;
  logic [LW-1:0]   gid;
  logic            locked;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int  m_ptr;
  int  m_lock;
  bit  m_locked;
  // Model expectations for the current cycle
  int            e_g;
  bit            e_valid;
  bit            e_last;
  logic [DW-1:0] e_data;
  logic [N-1:0]  e_ready;

  always #5 clk = ~clk;

  axi_burst_rr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .LOG_N_REQ(LW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .valid_o     (valid),
    .data_o      (data),
    .last_o      (last),
    .ready_i     (ready),
    .grant_id_o  (gid),
    .locked_o    (locked)
  );

  task automatic set_data(input int k, input logic [DW-1:0] v);
    req_data[k*DW +: DW] = v;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_locked = 0;
  endtask

  // Winner: locked requester, else first valid requester going round from m_ptr.
  task automatic model_eval();
    bit found;
    found = 0;
    if (m_locked) begin
      e_g = m_lock;
    end else begin
      e_g = m_ptr;
      for (int i = 0; i < N; i++) begin
        if (!found && req_valid[(m_ptr + i) % N]) begin
          e_g = (m_ptr + i) % N;
          found = 1;
        end
      end
    end
    e_valid = req_valid[e_g];
    e_data  = (m_locked || found) ? req_data[e_g*DW +: DW] : '0;
    e_last  = (m_locked || found) ? req_last[e_g] : 1'b0;
    e_ready = '0;
    if (m_locked || found) e_ready[e_g] = ready;
  endtask

  // Apply the burst rules for an accepted / presented beat at a clock edge.
  task automatic model_step();
    if (e_valid) begin
      if (!m_locked) begin
        if (ready && e_last) m_ptr = (e_g + 1) % N;
        else begin m_locked = 1; m_lock = e_g; end
      end else if (ready && e_last) begin
        m_locked = 0;
        m_ptr = (m_lock + 1) % N;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; ready = 1'b0; req_data = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_last = '0; ready = 1'b1;
    for (int k = 0; k < N; k++) set_data(k, $urandom);
    model_reset();
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (locked !== 1'b0 || gid !== 2'd0) begin n_bad++; $display("FAIL reset_lock_gid: got %b/%0d want 0/0", locked, gid); end
    n_cmp++; if (data !== 32'h0 || last !== 1'b0) begin n_bad++; $display("FAIL reset_data: got %h/%b want 0/0", data, last); end
    rst = 1'b0; #1;
    n_cmp++; if (gid !== 2'd0 || valid !== 1'b1) begin n_bad++; $display("FAIL reset_release: got gid %0d valid %b want 0/1", gid, valid); end
    n_cmp++; if (data !== req_data[0 +: DW]) begin n_bad++; $display("FAIL reset_release_data: got %h want %h", data, req_data[0 +: DW]); end
    req_last = '1;
    tick();
  endtask

  task automatic test_rr_fairness();
    do_reset();
    req_valid = '1; req_last = '1; ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < N; k++) set_data(k, 32'h1000 * c + k);
      @(negedge clk);
      n_cmp++; if (gid !== 2'(c % 4) || valid !== 1'b1) begin n_bad++; $display("FAIL rr_order c%0d: got gid %0d valid %b want %0d/1", c, gid, valid, c % 4); end
      n_cmp++; if (data !== 32'h1000 * c + (c % 4)) begin n_bad++; $display("FAIL rr_data c%0d: got %h want %h", c, data, 32'h1000 * c + (c % 4)); end
      tick();
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    ready = 1'b1; req_valid = 4'b0001;
    set_data(1, 32'hBEEF_0001); req_last[1] = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      if (b == 2) req_valid = 4'b0011;
      req_last[0] = (b == 4);
      set_data(0, 32'hA000_0000 + b);
      @(negedge clk);
      n_cmp++; if (gid !== 2'd0 || locked !== (b > 1)) begin n_bad++; $display("FAIL burst_beat%0d: got gid %0d locked %b want 0/%0d", b, gid, locked, b > 1); end
      n_cmp++; if (data !== 32'hA000_0000 + b || req_ready !== 4'b0001) begin n_bad++; $display("FAIL burst_data%0d: got %h rdy %b want %h/0001", b, data, req_ready, 32'hA000_0000 + b); end
      tick();
    end
    req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (gid !== 2'd1 || valid !== 1'b1 || locked !== 1'b0) begin n_bad++; $display("FAIL burst_next: got gid %0d valid %b locked %b want 1/1/0", gid, valid, locked); end
    n_cmp++; if (data !== 32'hBEEF_0001) begin n_bad++; $display("FAIL burst_next_data: got %h want beef0001", data); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0100; ready = 1'b0; req_last = 4'b0100;
    set_data(2, 32'hCAFE_0002); set_data(0, 32'h0000_00A0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) req_valid = 4'b0101;
      @(negedge clk);
      n_cmp++; if (gid !== 2'd2 || data !== 32'hCAFE_0002 || valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold c%0d: got gid %0d data %h valid %b want 2/cafe0002/1", c, gid, data, valid); end
      n_cmp++; if (locked !== (c > 0) || req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_lock c%0d: got locked %b rdy %b want %0d/0000", c, locked, req_ready, c > 0); end
      tick();
    end
    ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (gid !== 2'd2 || req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_accept: got gid %0d rdy %b want 2/0100", gid, req_ready); end
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++; if (gid !== 2'd0 || locked !== 1'b0 || data !== 32'h0000_00A0) begin n_bad++; $display("FAIL bp_after: got gid %0d locked %b data %h want 0/0/a0", gid, locked, data); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wrap_single();
    do_reset();
    ready = 1'b1; req_last = '1;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1010;
    @(negedge clk);
    n_cmp++; if (gid !== 2'd3 || locked !== 1'b0) begin n_bad++; $display("FAIL wrap_ptr3: got gid %0d locked %b want 3/0", gid, locked); end
    tick();
    @(negedge clk);
    n_cmp++; if (gid !== 2'd1 || valid !== 1'b1) begin n_bad++; $display("FAIL wrap_req1: got gid %0d valid %b want 1/1", gid, valid); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (locked !== 1'b0 || gid !== 2'd2 || valid !== 1'b0) begin n_bad++; $display("FAIL wrap_idle: got locked %b gid %0d valid %b want 0/2/0", locked, gid, valid); end
    n_cmp++; if (data !== 32'h0 || last !== 1'b0) begin n_bad++; $display("FAIL wrap_idle_data: got %h/%b want 0/0", data, last); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ready = 1'b1; req_valid = 4'b0011; req_last = 4'b0010;
    set_data(0, 32'h5555_0001); set_data(1, 32'h6666_0001);
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (valid !== 1'b0 || req_ready !== 4'b0000 || locked !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl: got valid %b rdy %b locked %b want 0/0000/0", valid, req_ready, locked); end
    n_cmp++; if (gid !== 2'd0 || data !== 32'h0 || last !== 1'b0) begin n_bad++; $display("FAIL rstmid_out: got gid %0d data %h last %b want 0/0/0", gid, data, last); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (gid !== 2'd0 || locked !== 1'b0 || data !== 32'h5555_0001) begin n_bad++; $display("FAIL rstmid_after: got gid %0d locked %b data %h want 0/0/55550001", gid, locked, data); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_last  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
      ready     = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) set_data(k, $urandom);
      @(negedge clk);
      model_eval();
      n_cmp++; if (gid !== LW'(e_g) || valid !== e_valid) begin n_bad++; $display("FAIL rand_grant c%0d: got gid %0d valid %b want %0d/%b", c, gid, valid, e_g, e_valid); end
      n_cmp++; if (data !== e_data || last !== e_last) begin n_bad++; $display("FAIL rand_data c%0d: got %h/%b want %h/%b", c, data, last, e_data, e_last); end
      n_cmp++; if (req_ready !== e_ready || locked !== m_locked) begin n_bad++; $display("FAIL rand_ctrl c%0d: got rdy %b locked %b want %b/%b", c, req_ready, locked, e_ready, m_locked); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_burst_lock();
    test_backpressure();
    test_wrap_single();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
